ahb_lite_cmd_master: RTL and testbench
======================================

Name: ahb_lite_cmd_master

Overview:
Upstream AHB-Lite master stage that drives the GPIO peripheral's slave port in the stimulus subsystem. It accepts word-sized read/write commands on a valid/ready interface and buffers them in a small FIFO. It issues them as single NONSEQ transfers with pipelined address/data phases, honouring slave wait states. Each completed transfer produces one response pulse carrying read data.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
ADDR_W, 32, HADDR width
DATA_W, 32, HWDATA/HRDATA width

Ports:
HCLK  in  1  clock, all logic on rising edge
HRESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address (word aligned)
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse per completed transfer
rsp_write  out  1  direction of completed transfer
rsp_rdata  out  DATA_W  HRDATA captured (reads); 0 for writes
HSEL  out  1  slave select
HADDR  out  ADDR_W  address phase address
HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only
HWRITE  out  1  address phase direction
HSIZE  out  3  fixed 3'b010 (word)
HWDATA  out  DATA_W  data phase write data
HREADY  out  1  to slave; = HREADYOUT (combinational pass-through)
HREADYOUT  in  1  slave ready
HRDATA  in  DATA_W  slave read data
busy  out  1  FIFO non-empty or any phase outstanding

Behaviour:
- Reset (HRESET high at edge): FIFO emptied. Address-phase and data-phase valid flags cleared. HTRANS=IDLE, HSEL=0, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0. Reset mid-transfer abandons it; no rsp is produced.
- Command accept: push when cmd_valid && cmd_ready; cmd_ready = !full (registered count). Push while full is ignored.
- Pipeline state is two flags, A (address phase valid) and D (data phase valid), with registered phase payloads.
- Bus advance: happens on an edge where HREADYOUT=1.
  - A moves to D; HWDATA loads the wdata of that command.
  - If the FIFO is non-empty, pop its head into A: HTRANS=NONSEQ, HSEL=1, HADDR/HWRITE from the entry.
  - Otherwise HTRANS=IDLE, HSEL=0, and HADDR/HWRITE hold.
- Wait states: HREADYOUT=0 holds HADDR, HTRANS, HWRITE, HSEL and HWDATA stable. No pop.
- Back-to-back throughput: one transfer per cycle with zero wait states. The address phase of N+1 overlaps the data phase of N.
- Latency: a command pushed into an empty idle block at edge t has its address phase during cycle t+1. Its data phase is in t+2. rsp_valid is asserted for cycle t+3 (zero wait states); each wait state adds 1.
- Response: when D is set and HREADYOUT=1 at an edge, register rsp_valid=1, rsp_write and rsp_rdata (HRDATA if read, else 0). rsp_valid deasserts the next cycle unless another transfer completes. There is no response backpressure.
- Simultaneous push and pop with the FIFO full is allowed: count unchanged, pointers wrap mod FIFO_DEPTH.
- busy = (count!=0) | A | D.
- HRESP is not used; the slave is always OKAY.
- Unaligned cmd_addr[1:0] is passed through unchanged; alignment is the caller's responsibility.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS_IDLE/HTRANS_NONSEQ localparams
  - HSIZE_WORD
  - a packed struct ahb_cmd_t {write, addr, wdata}
- Sub-module cmd_fifo (sync FIFO of ahb_cmd_t, FIFO_DEPTH, with count, full and empty outputs). The master FSM/pipeline is at top level.

Test Plan:
- Reset then single write: cmd {write=1, addr=0x5300_0000, wdata=0xA5} with HREADYOUT=1 -> HTRANS=NONSEQ for 1 cycle, HWDATA=0xA5 the next cycle, rsp_valid with rsp_write=1 three cycles after push.
- Single read: addr 0x5300_0004, slave returns HRDATA=0x0000_1234 -> rsp_valid=1, rsp_write=0, rsp_rdata=0x1234.
- Four back-to-back writes 0x1..0x4, zero waits -> four consecutive NONSEQ cycles, HWDATA 1,2,3,4 on consecutive cycles, four consecutive rsp pulses.
- Wait states: HREADYOUT=0 for 2 cycles during a data phase -> HADDR/HTRANS/HWDATA stable for those cycles, rsp delayed by exactly 2.
- FIFO full: push 5 commands with HREADYOUT=0 held -> cmd_ready=0 after entries fill (FIFO_DEPTH=4 plus 1 in address phase), no entry lost or duplicated after release.
- HRESET asserted during a data phase -> next cycle HTRANS=IDLE, HSEL=0, busy=0, no rsp_valid.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the command record carried through the master's FIFO.
package ahb_lite_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } ahb_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with a fall-through head so a pop can feed the address phase directly.
module cmd_fifo
  import ahb_lite_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   push_i,
  input  ahb_cmd_t               push_data_i,
  input  logic                   pop_i,
  output ahb_cmd_t               head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  ahb_cmd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only honoured when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite master: buffers word commands and issues single NONSEQ transfers with
// overlapped address/data phases, one response pulse per completed transfer.
module ahb_lite_cmd_master
  import ahb_lite_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HREADY,
  input  logic              HREADYOUT,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ahb_cmd_t          push_cmd;
  ahb_cmd_t          head_cmd;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic              a_q;
  logic              d_q;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [DATA_W-1:0] a_wdata_q;
  logic [DATA_W-1:0] hwdata_q;
  logic              d_write_q;
  logic              rsp_valid_q;
  logic              rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  always_comb begin
    push_cmd       = '0;
    push_cmd.write = cmd_write;
    push_cmd.addr  = cmd_addr;
    push_cmd.wdata = cmd_wdata;
  end

  assign push = cmd_valid && cmd_ready;
  assign pop  = HREADYOUT && !fifo_empty;

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i      (HCLK),
    .srst_i     (HRESET),
    .push_i     (push),
    .push_data_i(push_cmd),
    .pop_i      (pop),
    .head_o     (head_cmd),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Everything advances only on a ready edge; a wait state freezes both phases.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_q         <= 1'b0;
      d_q         <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      a_wdata_q   <= '0;
      hwdata_q    <= '0;
      d_write_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (HREADYOUT) begin
      rsp_valid_q <= d_q;
      if (d_q) begin
        rsp_write_q <= d_write_q;
        rsp_rdata_q <= d_write_q ? '0 : HRDATA;
      end
      d_q <= a_q;
      if (a_q) begin
        hwdata_q  <= a_wdata_q;
        d_write_q <= hwrite_q;
      end
      a_q <= !fifo_empty;
      if (!fifo_empty) begin
        haddr_q   <= head_cmd.addr;
        hwrite_q  <= head_cmd.write;
        a_wdata_q <= head_cmd.wdata;
      end
    end else begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign cmd_ready = !fifo_full;
  assign HSEL      = a_q;
  assign HTRANS    = a_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = HSIZE_WORD;
  assign HWDATA    = hwdata_q;
  assign HREADY    = HREADYOUT;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (fifo_count != '0) | a_q | d_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: queue-based transaction model checked every cycle,
// plus directed scenarios with literal timing/data expectations.
module tb_ahb_lite_cmd_master;

  localparam int DEPTH = 4;
  localparam int LOGN  = 4096;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT = 1'b1;
  logic [31:0] HRDATA = 32'hDEAD_0000;
  logic        busy;

  always #5 HCLK = ~HCLK;

  ahb_lite_cmd_master #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRDATA   (HRDATA),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model: a queue of pending commands and the command owning each bus phase.
  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
  } mcmd_t;

  mcmd_t       m_q[$];
  mcmd_t       m_a;
  mcmd_t       m_d;
  bit          m_a_v = 0;
  bit          m_d_v = 0;
  bit          m_rsp_v = 0;
  bit          m_rsp_w = 0;
  logic [31:0] m_rsp_d = '0;
  logic [31:0] m_haddr = '0;
  bit          m_hwrite = 0;
  logic [31:0] m_hwdata = '0;

  always @(posedge HCLK) begin
    bit push_now;
    cyc++;
    push_now = cmd_valid && (m_q.size() < DEPTH);
    if (HRESET) begin
      m_q.delete();
      m_a_v = 0; m_d_v = 0; m_rsp_v = 0; m_rsp_w = 0; m_rsp_d = '0;
      m_haddr = '0; m_hwrite = 0; m_hwdata = '0;
    end else begin
      if (HREADYOUT) begin
        m_rsp_v = m_d_v;
        if (m_d_v) begin
          m_rsp_w = m_d.w;
          m_rsp_d = m_d.w ? 32'h0 : HRDATA;
        end
        m_d_v = m_a_v;
        if (m_a_v) begin
          m_d = m_a;
          m_hwdata = m_a.d;
        end
        if (m_q.size() > 0) begin
          m_a = m_q.pop_front();
          m_a_v = 1;
          m_haddr = m_a.a;
          m_hwrite = m_a.w;
        end else begin
          m_a_v = 0;
        end
      end else begin
        m_rsp_v = 0;
      end
      if (push_now) m_q.push_back(mcmd_t'{w: cmd_write, a: cmd_addr, d: cmd_wdata});
    end
  end

  logic [1:0]  trans_at [LOGN];
  logic [31:0] hwdata_at[LOGN];
  bit          rspv_at  [LOGN];
  bit          rspw_at  [LOGN];
  logic [31:0] rspd_at  [LOGN];

  always @(negedge HCLK) begin
    if (chk_en) begin
      check("HTRANS", HTRANS, m_a_v ? 2'b10 : 2'b00);
      check("HSEL", HSEL, m_a_v);
      check("HADDR", HADDR, m_haddr);
      check("HWRITE", HWRITE, m_hwrite);
      check("HSIZE", HSIZE, 3'b010);
      check("HREADY", HREADY, HREADYOUT);
      check("cmd_ready", cmd_ready, m_q.size() < DEPTH);
      check("busy", busy, (m_q.size() != 0) || m_a_v || m_d_v);
      check("rsp_valid", rsp_valid, m_rsp_v);
      if (m_rsp_v) begin
        check("rsp_write", rsp_write, m_rsp_w);
        check("rsp_rdata", rsp_rdata, m_rsp_d);
      end
      if (m_d_v) check("HWDATA", HWDATA, m_hwdata);
    end
    if (cyc < LOGN) begin
      trans_at[cyc]  = HTRANS;
      hwdata_at[cyc] = HWDATA;
      rspv_at[cyc]   = rsp_valid;
      rspw_at[cyc]   = rsp_write;
      rspd_at[cyc]   = rsp_rdata;
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  // Offers one command until accepted; pe returns the accepting edge number.
  task automatic push(input bit w, input logic [31:0] a, input logic [31:0] d, output int pe);
    bit ok;
    ok = 0;
    pe = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 40; i++) begin
      ok = cmd_ready;
      tick();
      if (ok) begin
        pe = cyc;
        break;
      end
    end
    cmd_valid = 0;
    check("push_accepted", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int pe, p0, dummy, cnt;
    HRESET = 1;
    tick();
    chk_en = 1;
    tick();
    HRESET = 0;
    check("reset_HTRANS", HTRANS, 2'b00);
    check("reset_HADDR", HADDR, 32'h0);
    check("reset_HWDATA", HWDATA, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_cmd_ready", cmd_ready, 1'b1);

    // Single write: NONSEQ one cycle, data next, response three edges after push.
    push(1, 32'h5300_0000, 32'h0000_00A5, pe);
    repeat (5) tick();
    check("wr_nonseq", trans_at[pe+1], 2'b10);
    check("wr_nonseq_len", trans_at[pe+2], 2'b00);
    check("wr_hwdata", hwdata_at[pe+2], 32'hA5);
    check("wr_rsp_early", rspv_at[pe+2], 1'b0);
    check("wr_rsp", rspv_at[pe+3], 1'b1);
    check("wr_rsp_write", rspw_at[pe+3], 1'b1);
    check("wr_rsp_len", rspv_at[pe+4], 1'b0);

    // Single read returning 0x1234.
    HRDATA = 32'h0000_1234;
    push(0, 32'h5300_0004, 32'h0, pe);
    repeat (5) tick();
    check("rd_rsp", rspv_at[pe+3], 1'b1);
    check("rd_rsp_write", rspw_at[pe+3], 1'b0);
    check("rd_rsp_rdata", rspd_at[pe+3], 32'h1234);
    HRDATA = 32'hDEAD_0000;

    // Four back-to-back writes.
    push(1, 32'h5300_0010, 32'h1, p0);
    push(1, 32'h5300_0014, 32'h2, dummy);
    push(1, 32'h5300_0018, 32'h3, dummy);
    push(1, 32'h5300_001C, 32'h4, dummy);
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      check("b2b_nonseq", trans_at[p0+1+i], 2'b10);
      check("b2b_hwdata", hwdata_at[p0+2+i], 32'(i + 1));
      check("b2b_rsp", rspv_at[p0+3+i], 1'b1);
    end

    // Two wait states during the data phase.
    push(1, 32'h5300_0020, 32'h0000_BEEF, pe);
    tick();
    tick();
    HREADYOUT = 0;
    tick();
    tick();
    HREADYOUT = 1;
    repeat (4) tick();
    check("ws_hwdata_a", hwdata_at[pe+3], 32'hBEEF);
    check("ws_hwdata_b", hwdata_at[pe+4], 32'hBEEF);
    check("ws_rsp_held_a", rspv_at[pe+3], 1'b0);
    check("ws_rsp_held_b", rspv_at[pe+4], 1'b0);
    check("ws_rsp", rspv_at[pe+5], 1'b1);

    // FIFO full: one command in the address phase plus four queued.
    push(1, 32'h5300_0100, 32'h10, p0);
    push(0, 32'h5300_0104, 32'h11, dummy);
    HREADYOUT = 0;
    push(1, 32'h5300_0108, 32'h12, dummy);
    push(0, 32'h5300_010C, 32'h13, dummy);
    push(1, 32'h5300_0110, 32'h14, dummy);
    fork
      push(1, 32'h5300_0114, 32'h15, dummy);
      begin
        tick();
        check("full_cmd_ready", cmd_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        tick();
        HREADYOUT = 1;
      end
    join
    repeat (12) tick();
    cnt = 0;
    for (int c = p0; c <= cyc; c++) cnt += rspv_at[c] ? 1 : 0;
    check("full_rsp_count", cnt, 6);

    // Reset during a data phase abandons everything.
    HRDATA = 32'h0000_7777;
    push(0, 32'h5300_0200, 32'h0, pe);
    push(0, 32'h5300_0204, 32'h0, dummy);
    tick();
    HRESET = 1;
    tick();
    check("rst_mid_HTRANS", HTRANS, 2'b00);
    check("rst_mid_HSEL", HSEL, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rsp", rsp_valid, 1'b0);
    HRESET = 0;
    repeat (4) tick();
    check("rst_mid_no_rsp_a", rspv_at[pe+3], 1'b0);
    check("rst_mid_no_rsp_b", rspv_at[pe+4], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
